// File: rtl/pim_result_serializer.sv
// rtl/pim_result_serializer.sv - drains a captured wide PIM result as MSB-first words under valid/ready.
// Optional PIM_RESULT_SER_CLEAR_ON_READ_EN zeroes each drained slice and the whole buffer on clear.
module pim_result_serializer #(
  parameter int NUM_WORDS = 9,
  parameter int WORD_W    = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load,
  input  logic [NUM_WORDS*WORD_W-1:0] i_data,
  input  logic                        i_clear,
  output logic                        o_load_ready,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WORD_W-1:0]           o_data,
  output logic                        o_last,
  output logic [7:0]                  o_word_idx,
  output logic                        o_busy
);

  localparam int TOTAL_W = NUM_WORDS * WORD_W;
  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [7:0]         idx, idx_nxt;
  logic [TOTAL_W-1:0] result_buf, buf_nxt;
  logic [WORD_W-1:0]  cur_word;
  logic               draining;

  assign draining = (state == S_DRAIN);

  // Word 0 is the top slice, matching the MSB-first packing of the input path.
  always_comb begin
    cur_word = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (idx == 8'(w)) cur_word = result_buf[(NUM_WORDS-w)*WORD_W-1 -: WORD_W];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    buf_nxt   = result_buf;
    if (i_clear) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
`ifdef PIM_RESULT_SER_CLEAR_ON_READ_EN
      buf_nxt   = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_load) begin
            buf_nxt   = i_data;
            idx_nxt   = '0;
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_ready) begin
            if (idx == LAST_IDX) begin
              state_nxt = S_IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 8'd1;
            end
`ifdef PIM_RESULT_SER_CLEAR_ON_READ_EN
            for (int w = 0; w < NUM_WORDS; w++) begin
              if (idx == 8'(w)) buf_nxt[(NUM_WORDS-w)*WORD_W-1 -: WORD_W] = '0;
            end
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      result_buf <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      result_buf <= buf_nxt;
    end
  end

  // All outputs decode registered state only; i_ready never reaches them.
  assign o_valid      = draining;
  assign o_data       = draining ? cur_word : '0;
  assign o_last       = draining && (idx == LAST_IDX);
  assign o_word_idx   = draining ? idx : 8'd0;
  assign o_busy       = draining;
  assign o_load_ready = !draining;

endmodule

// File: tb/tb_pim_result_serializer.sv
// tb/tb_pim_result_serializer.sv - directed self-checking bench for pim_result_serializer.
// Expected buffer contents after drain/clear follow PIM_RESULT_SER_CLEAR_ON_READ_EN.
module tb_pim_result_serializer;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_load;
  logic [287:0] i_data;
  logic         i_clear;
  logic         o_load_ready;
  logic         o_valid;
  logic         i_ready;
  logic [31:0]  o_data;
  logic         o_last;
  logic [7:0]   o_word_idx;
  logic         o_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  w1 [9];
  logic [31:0]  w2 [9];
  logic [287:0] d1, d2;

  pim_result_serializer #(.NUM_WORDS(9), .WORD_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_data(i_data),
    .i_clear(i_clear), .o_load_ready(o_load_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_word_idx(o_word_idx), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [287:0] d);
    i_data = d;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  function automatic logic [287:0] buf_after_drain(input logic [287:0] d);
`ifdef PIM_RESULT_SER_CLEAR_ON_READ_EN
    return '0;
`else
    return d;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_idx;
    int cyc;

    for (int w = 0; w < 9; w++) begin
      w1[w] = {8{4'(w + 1)}};
      w2[w] = 32'hC0DE0000 + 32'(w);
    end
    d1 = '0;
    d2 = '0;
    for (int w = 0; w < 9; w++) begin
      d1 = {d1[255:0], w1[w]};
      d2 = {d2[255:0], w2[w]};
    end
    check("vec_top_word", d1[287:256], 32'h11111111);

    i_rst_n = 1'b0; i_load = 1'b0; i_data = '0; i_clear = 1'b0; i_ready = 1'b0;
    step(); step();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_idx", o_word_idx, 0);
    check("rst_busy", o_busy, 0);
    check("rst_load_ready", o_load_ready, 1);
    check("rst_buf", dut.result_buf, 0);
    i_rst_n = 1'b1;
    step();

    // Basic drain at full throughput
    i_ready = 1'b1;
    load(d1);
    for (int w = 0; w < 9; w++) begin
      check("drain_valid", o_valid, 1);
      check("drain_data", o_data, w1[w]);
      check("drain_idx", o_word_idx, 8'(w));
      check("drain_last", o_last, (w == 8));
      check("drain_load_ready", o_load_ready, 0);
      step();
    end
    check("drain_done_load_ready", o_load_ready, 1);
    check("drain_done_valid", o_valid, 0);
    check("drain_done_data", o_data, 0);
    check("drain_buf", dut.result_buf, buf_after_drain(d1));

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    i_ready = 1'b0;
    load(d2);
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < 9 && cyc < 60) begin
      i_ready = (cyc % 3 == 0);
      check("bp_valid", o_valid, 1);
      check("bp_data", o_data, w2[exp_idx]);
      check("bp_idx", o_word_idx, 8'(exp_idx));
      check("bp_last", o_last, (exp_idx == 8));
      step();
      if (i_ready) exp_idx++;
      cyc++;
    end
    i_ready = 1'b0;
    check("bp_done_valid", o_valid, 0);
    check("bp_done_load_ready", o_load_ready, 1);

    // Load pulse during DRAIN at word 4 must be ignored
    i_ready = 1'b1;
    load(d1);
    for (int w = 0; w < 9; w++) begin
      check("ld_drain_data", o_data, w1[w]);
      check("ld_drain_idx", o_word_idx, 8'(w));
      if (w == 4) begin
        i_data = d2;
        i_load = 1'b1;
      end
      step();
      i_load = 1'b0;
    end
    check("ld_drain_done_valid", o_valid, 0);
    check("ld_drain_buf", dut.result_buf, buf_after_drain(d1));

    // Clear at word 3 together with ready
    load(d2);
    for (int w = 0; w < 3; w++) begin
      check("clr_pre_data", o_data, w2[w]);
      step();
    end
    check("clr_at_idx", o_word_idx, 3);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clr_valid", o_valid, 0);
    check("clr_idx_out", o_word_idx, 0);
    check("clr_idx_reg", dut.idx, 0);
    check("clr_busy", o_busy, 0);
    check("clr_load_ready", o_load_ready, 1);
    check("clr_data", o_data, 0);
    check("clr_buf", dut.result_buf, buf_after_drain(d2));
    step();
    check("clr_stay_idle", o_valid, 0);

    // Async reset between edges at word 5
    load(d1);
    for (int w = 0; w < 5; w++) step();
    check("ar_at_word5", o_data, w1[5]);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_valid_now", o_valid, 0);
    check("ar_data_now", o_data, 0);
    check("ar_busy_now", o_busy, 0);
    step();
    i_rst_n = 1'b1;
    check("ar_buf", dut.result_buf, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("ar_after_valid", o_valid, 0);
      check("ar_after_load_ready", o_load_ready, 1);
    end

    // Fresh load after reset starts at word 0 with one-cycle latency
    load(d2);
    check("post_rst_data", o_data, w2[0]);
    check("post_rst_idx", o_word_idx, 0);
    i_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
